// File: rtl/ft600_chip_emulator.sv
`default_nettype none
// ============================================================================
// Module   : ft600_chip_emulator
// Brief    : FT600 chip-side model of the 245 synchronous FIFO interface with
//            host-side streams on both buffers.
// Revision : 1.0 - initial release
// ============================================================================
module ft600_chip_emulator #(
  parameter int EA = 10
) (
  input  logic        clk,
  input  logic        rstn_async,
  input  logic        host_tx_valid,
  output logic        host_tx_ready,
  input  logic [15:0] host_tx_data,
  input  logic [1:0]  host_tx_be,
  output logic        host_rx_valid,
  input  logic        host_rx_ready,
  output logic [15:0] host_rx_data,
  output logic [1:0]  host_rx_be,
  output logic        ftdi_rxf_n,
  output logic        ftdi_txe_n,
  input  logic        ftdi_oe_n,
  input  logic        ftdi_rd_n,
  input  logic        ftdi_wr_n,
  input  logic [15:0] ftdi_data_i,
  input  logic [1:0]  ftdi_be_i,
  output logic [15:0] ftdi_data_o,
  output logic [1:0]  ftdi_be_o,
  output logic        ftdi_data_oe,
  output logic        proto_err
);

  localparam int          c_DEPTH_N = 1 << EA;
  localparam logic [EA:0] c_DEPTH   = (EA+1)'(c_DEPTH_N);

  // Entries are stored as {be, data}.
  logic [17:0]   r_rx_mem [0:c_DEPTH_N-1];
  logic [17:0]   r_tx_mem [0:c_DEPTH_N-1];
  logic [EA-1:0] r_rx_wptr, r_rx_rptr, r_tx_wptr, r_tx_rptr;
  logic [EA:0]   r_rx_count, r_tx_count;
  logic          r_rxf_n, r_txe_n, r_host_tx_ready, r_proto_err;
  logic [17:0]   r_bus_head;

  logic          w_violation, w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
  logic [EA:0]   w_rx_count_next, w_tx_count_next;
  logic [EA-1:0] w_rx_rptr_next;
  logic [17:0]   w_rx_head_next, w_tx_head;

  assign w_violation = ~ftdi_wr_n & ~ftdi_oe_n;
  assign w_rx_push   = host_tx_valid & r_host_tx_ready;
  assign w_rx_pop    = ~r_rxf_n & ~ftdi_oe_n & ~ftdi_rd_n & ftdi_wr_n;
  // A zero-BE write completes the handshake but stores nothing.
  assign w_tx_push   = ~r_txe_n & ~ftdi_wr_n & ftdi_oe_n & (ftdi_be_i != 2'b00);
  assign w_tx_pop    = host_rx_valid & host_rx_ready;

  always_comb begin
    w_rx_count_next = r_rx_count;
    w_tx_count_next = r_tx_count;
    case ({w_rx_push, w_rx_pop})
      2'b10:   w_rx_count_next = r_rx_count + (EA+1)'(1);
      2'b01:   w_rx_count_next = r_rx_count - (EA+1)'(1);
      default: w_rx_count_next = r_rx_count;
    endcase
    case ({w_tx_push, w_tx_pop})
      2'b10:   w_tx_count_next = r_tx_count + (EA+1)'(1);
      2'b01:   w_tx_count_next = r_tx_count - (EA+1)'(1);
      default: w_tx_count_next = r_tx_count;
    endcase
  end

  // Next bus head; bypass the memory when the incoming word becomes the head.
  assign w_rx_rptr_next = r_rx_rptr + EA'(w_rx_pop);
  assign w_rx_head_next = (w_rx_push && (r_rx_wptr == w_rx_rptr_next))
                        ? {host_tx_be, host_tx_data} : r_rx_mem[w_rx_rptr_next];
  assign w_tx_head      = r_tx_mem[r_tx_rptr];

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= {host_tx_be, host_tx_data};
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= {ftdi_be_i, ftdi_data_i};
  end

  // Reset deassertion is expected to arrive synchronously to clk.
  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      r_rx_wptr       <= '0;
      r_rx_rptr       <= '0;
      r_rx_count      <= '0;
      r_tx_wptr       <= '0;
      r_tx_rptr       <= '0;
      r_tx_count      <= '0;
      r_rxf_n         <= 1'b1;
      r_txe_n         <= 1'b1;
      r_host_tx_ready <= 1'b0;
      r_bus_head      <= '0;
      r_proto_err     <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + EA'(1);
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + EA'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + EA'(1);
      r_rx_rptr       <= w_rx_rptr_next;
      r_rx_count      <= w_rx_count_next;
      r_tx_count      <= w_tx_count_next;
      r_rxf_n         <= (w_rx_count_next == '0);
      r_txe_n         <= (w_tx_count_next == c_DEPTH);
      r_host_tx_ready <= (w_rx_count_next < c_DEPTH);
      if (w_rx_count_next != '0) r_bus_head <= w_rx_head_next;
      if (w_violation)           r_proto_err <= 1'b1;
    end
  end

  assign host_tx_ready = r_host_tx_ready;
  assign host_rx_valid = (r_tx_count != '0);
  assign host_rx_data  = w_tx_head[15:0];
  assign host_rx_be    = w_tx_head[17:16];
  assign ftdi_rxf_n    = r_rxf_n;
  assign ftdi_txe_n    = r_txe_n;
  assign ftdi_data_o   = r_bus_head[15:0];
  assign ftdi_be_o     = r_bus_head[17:16];
  assign ftdi_data_oe  = ~ftdi_oe_n;
  assign proto_err     = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_ft600_chip_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_ft600_chip_emulator
// Brief    : Bench for ft600_chip_emulator; a deep (EA=10) and a shallow (EA=2)
//            instance share one stimulus and are each checked against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ft600_chip_emulator;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        host_tx_valid, host_rx_ready;
  logic [15:0] host_tx_data, ftdi_data_i;
  logic [1:0]  host_tx_be, ftdi_be_i;
  logic        ftdi_oe_n, ftdi_rd_n, ftdi_wr_n;
  int          ncmp = 0;
  int          nbad = 0;

  initial forever #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_u
    localparam int EAK   = (k == 0) ? 10 : 2;
    localparam int DEPTH = 1 << EAK;

    wire        host_tx_ready, host_rx_valid, rxf_n, txe_n, data_oe, perr;
    wire [15:0] rx_data, data_o;
    wire [1:0]  rx_be, be_o;

    ft600_chip_emulator #(.EA(EAK)) u_dut (
      .clk(clk), .rstn_async(rstn),
      .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
      .host_tx_data(host_tx_data), .host_tx_be(host_tx_be),
      .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
      .host_rx_data(rx_data), .host_rx_be(rx_be),
      .ftdi_rxf_n(rxf_n), .ftdi_txe_n(txe_n),
      .ftdi_oe_n(ftdi_oe_n), .ftdi_rd_n(ftdi_rd_n), .ftdi_wr_n(ftdi_wr_n),
      .ftdi_data_i(ftdi_data_i), .ftdi_be_i(ftdi_be_i),
      .ftdi_data_o(data_o), .ftdi_be_o(be_o),
      .ftdi_data_oe(data_oe), .proto_err(perr)
    );

    // Model: two queues of {be,data} plus the registered flags they imply.
    logic [17:0] rxq[$];
    logic [17:0] txq[$];
    logic        m_rxf_n, m_txe_n, m_ready, m_rxv, m_perr;
    logic [17:0] m_rxw, m_out;

    always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        rxq.delete();
        txq.delete();
        m_rxf_n <= 1'b1;
        m_txe_n <= 1'b1;
        m_ready <= 1'b0;
        m_rxv   <= 1'b0;
        m_rxw   <= '0;
        m_out   <= '0;
        m_perr  <= 1'b0;
      end else begin
        if (!m_rxf_n && !ftdi_oe_n && !ftdi_rd_n && ftdi_wr_n) void'(rxq.pop_front());
        if (host_tx_valid && m_ready) rxq.push_back({host_tx_be, host_tx_data});
        if (txq.size() != 0 && host_rx_ready) void'(txq.pop_front());
        if (!m_txe_n && !ftdi_wr_n && ftdi_oe_n && ftdi_be_i != 2'b00)
          txq.push_back({ftdi_be_i, ftdi_data_i});
        m_rxf_n <= (rxq.size() == 0);
        m_ready <= (rxq.size() < DEPTH);
        m_txe_n <= (txq.size() == DEPTH);
        m_rxv   <= (txq.size() != 0);
        if (txq.size() != 0) m_rxw <= txq[0];
        if (rxq.size() != 0) m_out <= rxq[0];
        if (!ftdi_wr_n && !ftdi_oe_n) m_perr <= 1'b1;
      end
    end

    wire [41:0] obs  = {rxf_n, txe_n, host_tx_ready, host_rx_valid,
                        m_rxv ? {rx_be, rx_data} : 18'h0, be_o, data_o, data_oe, perr};
    wire [41:0] expv = {m_rxf_n, m_txe_n, m_ready, m_rxv,
                        m_rxv ? m_rxw : 18'h0, m_out, ~ftdi_oe_n, m_perr};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle: wait for the sampling edge, then compare both instances to the model.
  task automatic cyc();
    @(negedge clk);
    ncmp++;
    if (g_u[0].obs !== g_u[0].expv) begin
      nbad++;
      $display("FAIL model_dut0: got %h expected %h (t=%0t)", g_u[0].obs, g_u[0].expv, $time);
    end
    ncmp++;
    if (g_u[1].obs !== g_u[1].expv) begin
      nbad++;
      $display("FAIL model_dut1: got %h expected %h (t=%0t)", g_u[1].obs, g_u[1].expv, $time);
    end
  endtask

  task automatic idle();
    host_tx_valid = 1'b0; host_tx_data = '0; host_tx_be = '0; host_rx_ready = 1'b0;
    ftdi_oe_n = 1'b1; ftdi_rd_n = 1'b1; ftdi_wr_n = 1'b1;
    ftdi_data_i = '0; ftdi_be_i = '0;
  endtask

  logic [15:0] wr_d [3] = '{16'hABCD, 16'h00EF, 16'h5555};
  logic [1:0]  wr_b [3] = '{2'b11, 2'b01, 2'b00};

  initial begin
    idle();
    repeat (3) cyc();
    chk("rst_rxf_n", g_u[0].rxf_n, 1);
    chk("rst_txe_n", g_u[0].txe_n, 1);
    chk("rst_tx_ready", g_u[0].host_tx_ready, 0);
    chk("rst_rx_valid", g_u[0].host_rx_valid, 0);
    chk("rst_perr", g_u[0].perr, 0);
    chk("rst_data_o", g_u[0].data_o, 0);

    // Reset release
    rstn = 1'b1;
    #1;
    chk("c0_txe_n", g_u[0].txe_n, 1);
    chk("c0_rxf_n", g_u[0].rxf_n, 1);
    cyc();
    chk("c1_txe_n", g_u[0].txe_n, 0);
    chk("c1_txe_n_small", g_u[1].txe_n, 0);
    chk("c1_tx_ready", g_u[0].host_tx_ready, 1);
    chk("c1_rxf_n", g_u[0].rxf_n, 1);

    // Host-to-FPGA read burst
    for (int i = 0; i < 3; i++) begin
      host_tx_valid = 1'b1; host_tx_be = 2'b11;
      host_tx_data = 16'h1111 * 16'(i + 1);
      cyc();
    end
    host_tx_valid = 1'b0;
    chk("burst_rxf_n", g_u[0].rxf_n, 0);
    ftdi_oe_n = 1'b0;
    cyc();
    ftdi_rd_n = 1'b0;
    #1;
    chk("burst_data_oe", g_u[0].data_oe, 1);
    for (int i = 0; i < 3; i++) begin
      chk("burst_data", g_u[0].data_o, 16'h1111 * 16'(i + 1));
      chk("burst_be", g_u[0].be_o, 2'b11);
      cyc();
    end
    chk("burst_end_rxf_n", g_u[0].rxf_n, 1);
    chk("burst_hold", g_u[0].data_o, 16'h3333);
    idle();

    // FPGA-to-host writes with byte-enable filtering
    for (int i = 0; i < 3; i++) begin
      ftdi_wr_n = 1'b0; ftdi_data_i = wr_d[i]; ftdi_be_i = wr_b[i];
      cyc();
    end
    idle();
    #1;
    chk("wr_valid0", g_u[0].host_rx_valid, 1);
    chk("wr_data0", g_u[0].rx_data, 16'hABCD);
    chk("wr_be0", g_u[0].rx_be, 2'b11);
    host_rx_ready = 1'b1;
    cyc();
    chk("wr_data1", g_u[0].rx_data, 16'h00EF);
    chk("wr_be1", g_u[0].rx_be, 2'b01);
    cyc();
    chk("wr_drop_be0", g_u[0].host_rx_valid, 0);
    idle();

    // Full and pointer wrap on the shallow instance
    for (int i = 0; i < 4; i++) begin
      host_tx_valid = 1'b1; host_tx_be = 2'b11; host_tx_data = 16'hA000 + 16'(i);
      cyc();
    end
    chk("full_ready", g_u[1].host_tx_ready, 0);
    chk("deep_ready", g_u[0].host_tx_ready, 1);
    for (int j = 0; j < 3; j++) begin
      host_tx_data = 16'hA004 + 16'(j);
      ftdi_oe_n = 1'b0; ftdi_rd_n = 1'b0;
      #1;
      chk("wrap_head", g_u[1].data_o, 16'hA000 + 16'(j));
      cyc();
      chk("refused_ready", g_u[1].host_tx_ready, 1);
      ftdi_oe_n = 1'b1; ftdi_rd_n = 1'b1;
      cyc();
      chk("refill_ready", g_u[1].host_tx_ready, 0);
    end
    host_tx_valid = 1'b0;
    ftdi_oe_n = 1'b0; ftdi_rd_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wrap_order", g_u[1].data_o, 16'hA003 + 16'(i));
      cyc();
    end
    idle();
    chk("wrap_empty", g_u[1].rxf_n, 1);

    // Protocol violation
    ftdi_wr_n = 1'b0; ftdi_oe_n = 1'b0; ftdi_data_i = 16'h1234; ftdi_be_i = 2'b11;
    cyc();
    chk("viol_perr", g_u[0].perr, 1);
    chk("viol_no_store", g_u[0].host_rx_valid, 0);
    idle();
    cyc();
    chk("viol_sticky", g_u[0].perr, 1);

    // Reset in the middle of a read burst
    for (int i = 0; i < 5; i++) begin
      host_tx_valid = 1'b1; host_tx_be = 2'b11; host_tx_data = 16'hB000 + 16'(i);
      ftdi_wr_n = (i == 0) ? 1'b0 : 1'b1; ftdi_data_i = 16'hC0DE; ftdi_be_i = 2'b11;
      cyc();
    end
    idle();
    chk("pre_rst_valid", g_u[0].host_rx_valid, 1);
    ftdi_oe_n = 1'b0; ftdi_rd_n = 1'b0;
    cyc();
    cyc();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    idle();
    cyc();
    chk("mid_rst_rxf_n", g_u[0].rxf_n, 1);
    chk("mid_rst_rxf_n_small", g_u[1].rxf_n, 1);
    chk("mid_rst_rx_valid", g_u[0].host_rx_valid, 0);
    chk("mid_rst_perr", g_u[0].perr, 0);
    chk("mid_rst_data_o", g_u[0].data_o, 0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ft600_chip_emulator.md
Name: ft600_chip_emulator

Overview:
- Synthesizable emulator of the FT600 chip side of the 245-sync-FIFO interface: the slave that the FPGA-side 245fifo controller talks to.
- Holds two word buffers. The host-to-FPGA buffer is filled from a host-side stream and drained by the master over RXF_N/OE_N/RD_N. The FPGA-to-host buffer is filled by the master over TXE_N/WR_N and drained to a host-side stream.
- Used in loopback benches and FPGA self-test builds that run without a real FT600. Everything runs on `clk`, which also stands in for the FT600 CLK pin.

Parameters:
- `EA`, 10, log2 of each buffer depth in 16-bit words (depth = 2^EA).

Ports:
- `clk`  in  1  single clock; emulated ftdi_clk, also the host-stream clock
- `rstn_async`  in  1  asynchronous active-low reset
- `host_tx_valid`  in  1  host->FPGA word valid
- `host_tx_ready`  out  1  host->FPGA buffer can accept
- `host_tx_data`  in  16  host->FPGA word
- `host_tx_be`  in  2  host->FPGA byte enables
- `host_rx_valid`  out  1  FPGA->host word available
- `host_rx_ready`  in  1  host consumes word
- `host_rx_data`  out  16  FPGA->host word
- `host_rx_be`  out  2  FPGA->host byte enables
- `ftdi_rxf_n`  out  1  low = host->FPGA data available
- `ftdi_txe_n`  out  1  low = FPGA->host space available
- `ftdi_oe_n`  in  1  master output-enable request
- `ftdi_rd_n`  in  1  master read strobe
- `ftdi_wr_n`  in  1  master write strobe
- `ftdi_data_i`  in  16  bus value driven by master
- `ftdi_be_i`  in  2  BE driven by master
- `ftdi_data_o`  out  16  bus value driven by emulator
- `ftdi_be_o`  out  2  BE driven by emulator
- `ftdi_data_oe`  out  1  emulator bus drive enable
- `proto_err`  out  1  sticky protocol-violation flag

Behaviour:
- **Clock and reset.** Async, active-low reset, released synchronously to `clk`. Under reset:
  - Both buffers empty; counts (EA+1 bits) = 0.
  - `ftdi_rxf_n` = 1, `ftdi_txe_n` = 1 (registered flags).
  - `proto_err` = 0; `host_rx_valid` = 0; `host_tx_ready` = 0.
  - `ftdi_data_o` = 0, `ftdi_be_o` = 0.
  - A reset mid-burst discards all buffered words.
- **Flags.** Both are registered:
  - `ftdi_rxf_n` <= (rx_count_next == 0).
  - `ftdi_txe_n` <= (tx_count_next == 2^EA).
  - Hence `ftdi_txe_n` falls 1 cycle after reset release.
- **Host push.** `host_tx_ready` = registered (rx_count < 2^EA).
  - A word is stored on a `clk` edge with valid & ready.
  - When full, the push is refused even if the master pops in the same cycle.
- **Master read.** A word is consumed on an edge where `ftdi_rxf_n`=0 & `ftdi_oe_n`=0 & `ftdi_rd_n`=0.
  - `ftdi_data_o`/`ftdi_be_o` present the buffer head (show-ahead) with 0 added latency.
  - The next word appears in the cycle after each consumption.
  - When the buffer is empty, the outputs hold their last value.
  - `ftdi_rd_n`=0 with `ftdi_oe_n`=1: no transfer, pointer unchanged.
- **Bus drive.** `ftdi_data_oe` = ~`ftdi_oe_n` (combinational). The master must not drive while `ftdi_oe_n`=0.
- **Master write.** A word is accepted on an edge where `ftdi_txe_n`=0 & `ftdi_wr_n`=0 & `ftdi_oe_n`=1.
  - `ftdi_be_i` = 2'b00: handshake completes but nothing is stored.
  - Writes while `ftdi_txe_n`=1 are dropped silently.
- **Host pop.** `host_rx_valid` = (tx_count != 0); data and BE come from the head (show-ahead). Pop on valid & ready.
- **Simultaneous operations.** Push and pop on the same buffer in one cycle leave the count unchanged; the pointers wrap modulo 2^EA.
- **Protocol violation.** `ftdi_wr_n`=0 & `ftdi_oe_n`=0 on any edge:
  - No transfer in either direction.
  - `proto_err` <= 1 and stays set until reset.

Test Plan:
- **Reset release.** Reset, then release → `ftdi_rxf_n`=1, `ftdi_txe_n`=1 in cycle 0; `ftdi_txe_n`=0 in cycle 1; `host_tx_ready`=1 in cycle 1.
- **Host-to-FPGA read burst.** Push 0x1111, 0x2222, 0x3333 (be=11); master holds OE_N low, then RD_N low for 3 cycles → bus shows 0x1111/0x2222/0x3333 on consecutive cycles; `ftdi_rxf_n`=1 the cycle after the third read.
- **FPGA-to-host write with BE filtering.** Master writes 0xABCD be=11, 0x00EF be=01, 0x5555 be=00 → host_rx yields 0xABCD/11, then 0x00EF/01, then `host_rx_valid`=0 (third word dropped).
- **Full / wrap with EA=2.** Push 4 words → `host_tx_ready`=0. Master reads 1 word while the host keeps valid high → the push is refused that cycle and accepted the next. Repeat 3 times; the data order is preserved across pointer wrap.
- **Protocol violation.** WR_N=0 with OE_N=0 while `ftdi_txe_n`=0 → tx_count unchanged, `proto_err`=1 and remains set after WR_N is released.
- **Reset mid-transfer.** Assert reset during a read burst with 5 words buffered → after release `ftdi_rxf_n`=1 and `host_rx_valid`=0.
